axil_master_arbiter: RTL

- Shares one AXI4-Lite master port between NUM_REQ simple requesters, one single-beat read or write in flight at a time.
- Sits between in-fabric command sources (test sequencers, config engines) and the AXI interconnect or AXI VIP slave memory in the block design.
- Arbitration is round-robin.
- Aggregates non-OKAY responses into a sticky ERROR flag for the testbench.

---
 rtl/axil_arb_pkg.sv | 42 ++++
 rtl/axil_master_arbiter_rr.sv | 33 +++
 rtl/axil_master_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/axil_arb_pkg.sv
// Shared types, AXI response codes and the round-robin grant function
// used by the AXI4-Lite master arbiter.
package axil_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int MAX_REQ = 8;

    // Returns {found, index}: first set bit of req at or after ptr, wrapping at numReq.
    function automatic logic [3:0] next_grant(input logic [7:0] req,
                                              input logic [2:0] ptr,
                                              input int         numReq);
        logic       found;
        logic [2:0] idx;
        logic [3:0] pos;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < MAX_REQ; k++) begin
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= 4'(numReq)) begin
                pos = pos - 4'(numReq);
            end
            if (!found && (k < numReq) && req[pos[2:0]]) begin
                found = 1'b1;
                idx   = pos[2:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/axil_master_arbiter_rr.sv
// Combinational round-robin arbiter: request vector plus rotating pointer
// in, one-hot grant and its index out.
module rr_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grantIdx,
    output logic               anyReq
);

    logic [7:0] reqPad;
    logic [2:0] ptrPad;
    logic [3:0] result;

    always_comb begin
        reqPad                 = '0;
        reqPad[NUM_REQ-1:0]    = req;
        ptrPad                 = '0;
        ptrPad[IDX_W-1:0]      = ptr;
        result                 = next_grant(reqPad, ptrPad, NUM_REQ);
        anyReq                 = result[3];
        grantIdx               = result[IDX_W-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = result[3] && (result[2:0] == 3'(i));
        end
    end

endmodule

// File: rtl/axil_master_arbiter.sv
// Shares one AXI4-Lite master port between NUM_REQ requesters, one single-beat
// transaction at a time, with round-robin arbitration and a sticky error flag.
module axil_master_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ-1:0]        REQ_WE,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_WDATA,
    output logic [NUM_REQ-1:0]        ACK,
    output logic [DATA_W-1:0]         RDATA_OUT,
    output logic                      RESP_ERR,
    output logic                      ERROR,
    output logic [ADDR_W-1:0]         AWADDR,
    output logic [2:0]                AWPROT,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [DATA_W-1:0]         WDATA,
    output logic [DATA_W/8-1:0]       WSTRB,
    output logic                      WVALID,
    input  logic                      WREADY,
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,
    output logic [ADDR_W-1:0]         ARADDR,
    output logic [2:0]                ARPROT,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    input  logic [DATA_W-1:0]         RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RVALID,
    output logic                      RREADY
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               state, stateNext;
    logic [IDX_W-1:0]     ptr, grantIdxQ, arbIdx;
    logic [NUM_REQ-1:0]   arbGrant, grantQ;
    logic                 anyReq;
    logic                 awDone, wDone;
    logic                 awFire, wFire, bFire, arFire, rFire;
    logic [ADDR_W-1:0]    addrQ;
    logic [DATA_W-1:0]    wdataQ, rdataQ;
    logic [1:0]           respQ;
    logic                 errorQ;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req      (REQ),
        .ptr      (ptr),
        .grant    (arbGrant),
        .grantIdx (arbIdx),
        .anyReq   (anyReq)
    );

    assign awFire = AWVALID && AWREADY;
    assign wFire  = WVALID && WREADY;
    assign bFire  = BVALID && BREADY;
    assign arFire = ARVALID && ARREADY;
    assign rFire  = RVALID && RREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // AW and W complete independently; leave WR once both have handshaken.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (anyReq) stateNext = REQ_WE[arbIdx] ? WR : RD_ADDR;
            WR:      if ((awDone || awFire) && (wDone || wFire)) stateNext = WR_RESP;
            WR_RESP: if (bFire) stateNext = DONE;
            RD_ADDR: if (arFire) stateNext = RD_DATA;
            RD_DATA: if (rFire) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ptr       <= '0;
            grantIdxQ <= '0;
            grantQ    <= '0;
            addrQ     <= '0;
            wdataQ    <= '0;
            awDone    <= 1'b0;
            wDone     <= 1'b0;
            respQ     <= RESP_OKAY;
            rdataQ    <= '0;
            errorQ    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        grantIdxQ <= arbIdx;
                        grantQ    <= arbGrant;
                        addrQ     <= REQ_ADDR[arbIdx*ADDR_W +: ADDR_W];
                        wdataQ    <= REQ_WDATA[arbIdx*DATA_W +: DATA_W];
                        awDone    <= 1'b0;
                        wDone     <= 1'b0;
                    end
                end
                WR: begin
                    if (awFire) awDone <= 1'b1;
                    if (wFire)  wDone  <= 1'b1;
                end
                WR_RESP: begin
                    if (bFire) respQ <= BRESP;
                end
                RD_DATA: begin
                    if (rFire) begin
                        respQ  <= RRESP;
                        rdataQ <= RDATA;
                    end
                end
                DONE: begin
                    errorQ <= errorQ | (respQ != RESP_OKAY);
                    ptr    <= (grantIdxQ == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdxQ + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign AWVALID   = (state == WR) && !awDone;
    assign WVALID    = (state == WR) && !wDone;
    assign AWADDR    = addrQ;
    assign WDATA     = wdataQ;
    assign WSTRB     = '1;
    assign AWPROT    = 3'b000;
    assign BREADY    = (state == WR_RESP);
    assign ARVALID   = (state == RD_ADDR);
    assign ARADDR    = addrQ;
    assign ARPROT    = 3'b000;
    assign RREADY    = (state == RD_DATA);
    assign ACK       = (state == DONE) ? grantQ : '0;
    assign RDATA_OUT = rdataQ;
    assign RESP_ERR  = (state == DONE) && (respQ != RESP_OKAY);
    assign ERROR     = errorQ;

endmodule
